cpu_debug_sequencer: RTL and testbench
======================================

Name: cpu_debug_sequencer

Overview:
- Command-driven controller that sits directly upstream of the core's control-module port.
- Drives cm_cpu_stop, cm_read_write_regfile_addr and cm_write_regfile_dat; consumes cm_read_regfile_dat.
- Sequences halt/resume, full register-file dumps as a valid/ready stream, and single-register writes for fault injection.
- Commands come from the SOC host link over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, register/data width
- REG_ADDR_WIDTH, 5, register-file address width
- NUM_REGS, 32, registers covered by a dump (addresses 0..NUM_REGS-1)
- SETTLE_CYCLES, 2, cycles after cm_cpu_stop rises before the first regfile access

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid
- cmd_op  in  2  command: 0 HALT, 1 RESUME, 2 DUMP, 3 WRITE
- cmd_addr  in  REG_ADDR_WIDTH  target register for WRITE
- cmd_data  in  DATA_WIDTH  write value for WRITE
- dump_valid  out  1  dump word present
- dump_ready  in  1  consumer accepts dump word
- dump_data  out  DATA_WIDTH  register contents
- dump_last  out  1  high with the word for address NUM_REGS-1
- cm_cpu_stop  out  1  core clock gate
- cm_read_write_regfile_addr  out  REG_ADDR_WIDTH  regfile address
- cm_write_regfile_dat  out  DATA_WIDTH  write data
- cm_regfile_wr_enb  out  1  one-cycle regfile write strobe
- halted  out  1  core is held stopped by a HALT command

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low; it is sampled on the clk rising edge only.
- Reset values: all outputs 0, FSM in IDLE, halted flag 0, address counter 0. Reset mid-operation aborts any dump or write immediately. No dump_last is emitted after reset, and cm_cpu_stop drops on the next edge.
- cmd_ready is high only in IDLE. A command is accepted on the edge where cmd_valid and cmd_ready are both high. cmd_addr and cmd_data are captured at acceptance.
- cm_cpu_stop is registered. It is 1 in every state except IDLE, and is also 1 in IDLE while halted=1.
- States and transitions:
  - IDLE
    - HALT: set halted, go to IDLE (one-cycle accept).
    - RESUME: clear halted, stay in IDLE. cm_cpu_stop falls on the next edge, or stays low if already low.
    - DUMP or WRITE: if halted=1, go directly to ACCESS. Otherwise go to SETTLE and load the counter with SETTLE_CYCLES-1.
  - SETTLE: decrement the counter each cycle; at 0, go to ACCESS.
  - ACCESS (DUMP): drive cm_read_write_regfile_addr = current index, hold 1 cycle for combinational read settle, go to OUT.
  - OUT
    - Register cm_read_regfile_dat into dump_data and assert dump_valid. Hold dump_data stable while dump_valid=1 and dump_ready=0.
    - dump_last=1 when index = NUM_REGS-1.
    - On dump_valid & dump_ready: if last, go to DONE; else increment index and go to ACCESS.
  - ACCESS (WRITE): drive addr = captured cmd_addr, cm_write_regfile_dat = captured cmd_data, pulse cm_regfile_wr_enb for exactly 1 cycle, go to DONE.
  - DONE: deassert dump_valid and wr strobe, reset index to 0, go to IDLE. cm_cpu_stop returns to the halted flag value.
- Dump latency: the first dump_valid is SETTLE_CYCLES+2 cycles after acceptance when not halted, 2 cycles when halted. With dump_ready held high, each word takes 2 cycles.
- Address counter width is REG_ADDR_WIDTH. When NUM_REGS equals 2^REG_ADDR_WIDTH, it must not wrap before dump_last is detected; use an equality compare, not overflow.
- Register 0 is dumped like any other address and reads as the core supplies it.
- WRITE to address 0 is issued normally; the core discards it.
- cmd_valid while busy: ignored (cmd_ready=0); the command must be held by the sender.
- Simultaneous dump_ready with dump_valid low has no effect.
- The regfile address bus is 0 whenever not in ACCESS or OUT. It is held at the dump index during OUT.

Test Plan:
- Reset then HALT accepted -> cm_cpu_stop=1 and halted=1 on the next edge. RESUME -> both 0 on the following edge. Reset with rst=0 for 1 cycle mid-HALT clears both.
- Not halted, DUMP, SETTLE_CYCLES=2, dump_ready=1, regfile model x[i]=0x1000_0000+i -> 32 words 0x1000_0000..0x1000_001F. First word 4 cycles after acceptance; dump_last only on the 32nd word; cm_cpu_stop=0 after DONE.
- DUMP with dump_ready toggling 1-0-0-1 -> dump_data held stable across stalls, no word lost or duplicated, order preserved.
- Halted, WRITE addr=5 data=0xDEADBEEF -> single cm_regfile_wr_enb pulse with addr=5 and dat=0xDEADBEEF; no SETTLE state; cm_cpu_stop remains 1 after DONE.
- cmd_valid with a new DUMP held during an active dump -> cmd_ready=0 until IDLE, then accepted exactly once.
- rst asserted on the 10th dump word -> dump_valid=0, cm_cpu_stop=0 next edge. A new DUMP restarts at address 0.

Source files
------------

// File: rtl/cpu_debug_sequencer.sv
// Debug command sequencer in front of the core control-module port.
// Accepts HALT / RESUME / DUMP / WRITE commands from the host link and
// sequences core stop, full register-file dumps and single-register writes.
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   cmd_valid/cmd_ready         host command handshake
//   cmd_op/cmd_addr/cmd_data    opcode (0 HALT, 1 RESUME, 2 DUMP, 3 WRITE), WRITE target and value
//   dump_valid/dump_ready       register dump stream handshake
//   dump_data/dump_last         dump word, marker on address NUM_REGS-1
//   cm_cpu_stop                 core clock gate
//   cm_read_write_regfile_addr  regfile address
//   cm_write_regfile_dat        regfile write data
//   cm_regfile_wr_enb           single-cycle regfile write strobe
//   cm_read_regfile_dat         regfile read data (combinational from the core)
//   halted                      core held stopped by a HALT command
module cpu_debug_sequencer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned SETTLE_CYCLES  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [REG_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_data,
    output logic                      dump_valid,
    input  logic                      dump_ready,
    output logic [DATA_WIDTH-1:0]     dump_data,
    output logic                      dump_last,
    output logic                      cm_cpu_stop,
    output logic [REG_ADDR_WIDTH-1:0] cm_read_write_regfile_addr,
    output logic [DATA_WIDTH-1:0]     cm_write_regfile_dat,
    output logic                      cm_regfile_wr_enb,
    input  logic [DATA_WIDTH-1:0]     cm_read_regfile_dat,
    output logic                      halted
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD =
        CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [REG_ADDR_WIDTH-1:0] LAST_IDX = REG_ADDR_WIDTH'(NUM_REGS - 1);

    localparam logic [1:0] OP_HALT   = 2'd0;
    localparam logic [1:0] OP_RESUME = 2'd1;
    localparam logic [1:0] OP_WRITE  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ACCESS,
        S_OUT,
        S_DONE
    } state_t;

    state_t                    state;
    logic                      is_write;
    logic [REG_ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0]     cap_data;
    logic [REG_ADDR_WIDTH-1:0] idx;
    logic [CNT_W-1:0]          settle_cnt;

    // Sequencer: every output is registered and updated on the transition
    // into the state that owns it, so ACCESS sees a stable address all cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state                      <= S_IDLE;
            halted                     <= 1'b0;
            is_write                   <= 1'b0;
            cap_addr                   <= '0;
            cap_data                   <= '0;
            idx                        <= '0;
            settle_cnt                 <= '0;
            cmd_ready                  <= 1'b0;
            dump_valid                 <= 1'b0;
            dump_data                  <= '0;
            dump_last                  <= 1'b0;
            cm_cpu_stop                <= 1'b0;
            cm_read_write_regfile_addr <= '0;
            cm_write_regfile_dat       <= '0;
            cm_regfile_wr_enb          <= 1'b0;
        end else begin
            cm_regfile_wr_enb <= 1'b0;

            case (state)
                S_IDLE: begin
                    cmd_ready   <= 1'b1;
                    cm_cpu_stop <= halted;
                    if (cmd_valid && cmd_ready) begin
                        case (cmd_op)
                            OP_HALT: begin
                                halted      <= 1'b1;
                                cm_cpu_stop <= 1'b1;
                            end
                            OP_RESUME: begin
                                halted      <= 1'b0;
                                cm_cpu_stop <= 1'b0;
                            end
                            default: begin
                                cmd_ready   <= 1'b0;
                                cm_cpu_stop <= 1'b1;
                                is_write    <= (cmd_op == OP_WRITE);
                                cap_addr    <= cmd_addr;
                                cap_data    <= cmd_data;
                                idx         <= '0;
                                // Core already stopped: no need to wait for it to quiesce.
                                if (halted || (SETTLE_CYCLES == 0)) begin
                                    state <= S_ACCESS;
                                    if (cmd_op == OP_WRITE) begin
                                        cm_read_write_regfile_addr <= cmd_addr;
                                        cm_write_regfile_dat       <= cmd_data;
                                        cm_regfile_wr_enb          <= 1'b1;
                                    end else begin
                                        cm_read_write_regfile_addr <= '0;
                                    end
                                end else begin
                                    state      <= S_SETTLE;
                                    settle_cnt <= SETTLE_LOAD;
                                end
                            end
                        endcase
                    end
                end

                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_ACCESS;
                        if (is_write) begin
                            cm_read_write_regfile_addr <= cap_addr;
                            cm_write_regfile_dat       <= cap_data;
                            cm_regfile_wr_enb          <= 1'b1;
                        end else begin
                            cm_read_write_regfile_addr <= idx;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end

                // Address has been stable for a full cycle; sample the read port.
                S_ACCESS: begin
                    if (is_write) begin
                        state                      <= S_DONE;
                        cm_read_write_regfile_addr <= '0;
                        cm_write_regfile_dat       <= '0;
                    end else begin
                        state      <= S_OUT;
                        dump_data  <= cm_read_regfile_dat;
                        dump_valid <= 1'b1;
                        dump_last  <= (idx == LAST_IDX);
                    end
                end

                // Word held until taken; equality compare on idx avoids wrap issues.
                S_OUT: begin
                    if (dump_valid && dump_ready) begin
                        dump_valid <= 1'b0;
                        dump_last  <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state                      <= S_DONE;
                            cm_read_write_regfile_addr <= '0;
                        end else begin
                            state                      <= S_ACCESS;
                            idx                        <= idx + REG_ADDR_WIDTH'(1);
                            cm_read_write_regfile_addr <= idx + REG_ADDR_WIDTH'(1);
                        end
                    end
                end

                S_DONE: begin
                    state                      <= S_IDLE;
                    dump_valid                 <= 1'b0;
                    dump_last                  <= 1'b0;
                    idx                        <= '0;
                    cm_read_write_regfile_addr <= '0;
                    cm_write_regfile_dat       <= '0;
                    cm_cpu_stop                <= halted;
                    cmd_ready                  <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_debug_sequencer.sv
// Self-checking bench for cpu_debug_sequencer: table-driven command list,
// hand-written corner sequences and a randomized phase, all checked against
// a command-level model of halted state and register-file contents.
module tb_cpu_debug_sequencer;

    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 5;
    localparam int unsigned NR     = 32;
    localparam int unsigned SC     = 2;
    localparam int          BUDGET = 2000;
    localparam logic [DW-1:0] INIT_BASE = 32'h1000_0000;

    localparam logic [1:0] OP_HALT   = 2'd0;
    localparam logic [1:0] OP_RESUME = 2'd1;
    localparam logic [1:0] OP_DUMP   = 2'd2;
    localparam logic [1:0] OP_WRITE  = 2'd3;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          dump_valid;
    logic          dump_ready;
    logic [DW-1:0] dump_data;
    logic          dump_last;
    logic          cm_cpu_stop;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdat;
    logic          rf_wr;
    logic [DW-1:0] rf_rdat;
    logic          halted;

    cpu_debug_sequencer #(
        .DATA_WIDTH    (DW),
        .REG_ADDR_WIDTH(AW),
        .NUM_REGS      (NR),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .cmd_valid                 (cmd_valid),
        .cmd_ready                 (cmd_ready),
        .cmd_op                    (cmd_op),
        .cmd_addr                  (cmd_addr),
        .cmd_data                  (cmd_data),
        .dump_valid                (dump_valid),
        .dump_ready                (dump_ready),
        .dump_data                 (dump_data),
        .dump_last                 (dump_last),
        .cm_cpu_stop               (cm_cpu_stop),
        .cm_read_write_regfile_addr(rf_addr),
        .cm_write_regfile_dat      (rf_wdat),
        .cm_regfile_wr_enb         (rf_wr),
        .cm_read_regfile_dat       (rf_rdat),
        .halted                    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core register file: combinational read, register 0 discards writes,
    // contents reload with a known pattern while reset is held.
    logic [DW-1:0] core_regs [NR];
    assign rf_rdat = core_regs[rf_addr];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(NR); i++) core_regs[i] <= INIT_BASE + DW'(i);
        end else if (rf_wr && rf_addr != '0) begin
            core_regs[rf_addr] <= rf_wdat;
        end
    end

    // Reference model: what the host believes the core holds and whether it is halted.
    logic [DW-1:0] ref_regs [NR];
    bit            ref_halted;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        ref_halted = 1'b0;
        for (int i = 0; i < int'(NR); i++) ref_regs[i] = INIT_BASE + DW'(i);
    endtask

    // Observation index k counts cycles after the acceptance edge (k=0 is the
    // first cycle after the accept cycle), so a latency of L cycles is k=L-1.
    function automatic int exp_k(input logic [1:0] op, input bit hlt);
        if (op == OP_DUMP)  return (hlt ? 2 : int'(SC) + 2) - 1;
        if (op == OP_WRITE) return (hlt ? 1 : int'(SC) + 1) - 1;
        return -1;
    endfunction

    // Issue one command, follow it back to IDLE and check everything observed.
    // mode: 0 dump_ready high, 1 ready pattern 1-0-0-1, 2 random ready.
    task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int mode, input int exp_lat);
        logic [DW-1:0] exp_words [NR];
        int k, widx, first_k, strobes, wait_n;
        for (int i = 0; i < int'(NR); i++) exp_words[i] = ref_regs[i];
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        wait_n    = 0;
        while (!cmd_ready && wait_n < 100) begin
            if (mode == 2) dump_ready = 1'($urandom_range(0, 1));
            tick();
            wait_n++;
        end
        check("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        tick();
        cmd_valid = 1'b0;
        case (op)
            OP_HALT:   ref_halted = 1'b1;
            OP_RESUME: ref_halted = 1'b0;
            OP_WRITE:  if (a != '0) ref_regs[a] = d;
            default:   ;
        endcase

        k = 0; widx = 0; first_k = -1; strobes = 0;
        while (!cmd_ready && k < BUDGET) begin
            case (mode)
                0:       dump_ready = 1'b1;
                1:       dump_ready = ((k % 4) == 0) || ((k % 4) == 3);
                default: dump_ready = 1'($urandom_range(0, 1));
            endcase
            check("busy_cpu_stop", 32'(cm_cpu_stop), 32'd1);
            if (dump_valid) begin
                if (first_k < 0) first_k = k;
                if (widx < int'(NR)) begin
                    check("dump_data", dump_data, exp_words[widx]);
                    check("dump_last", 32'(dump_last), 32'(widx == int'(NR) - 1));
                    check("dump_addr", 32'(rf_addr), 32'(widx));
                end else begin
                    check("dump_word_overrun", 32'(widx), 32'(NR - 1));
                end
                if (dump_ready) widx++;
            end else begin
                check("dump_last_without_valid", 32'(dump_last), 32'd0);
            end
            if (rf_wr) begin
                strobes++;
                if (first_k < 0) first_k = k;
                check("wr_addr", 32'(rf_addr), 32'(a));
                check("wr_data", rf_wdat, d);
            end
            tick();
            k++;
        end
        check("cmd_complete", 32'(cmd_ready), 32'd1);
        check("halted_after", 32'(halted), 32'(ref_halted));
        check("cpu_stop_after", 32'(cm_cpu_stop), 32'(ref_halted));
        check("addr_idle", 32'(rf_addr), 32'd0);
        if (op == OP_DUMP) begin
            check("dump_word_count", 32'(widx), 32'(NR));
            check("dump_first_latency", 32'(first_k), 32'(exp_lat));
            check("dump_no_write", 32'(strobes), 32'd0);
        end
        if (op == OP_WRITE) begin
            check("wr_strobe_count", 32'(strobes), 32'd1);
            check("wr_latency", 32'(first_k), 32'(exp_lat));
        end
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            mode;
        int            exp_lat;
        bit            exp_halted;
    } vec_t;

    vec_t vecs [13];

    int acc, words, words_at_2nd, k;
    logic [1:0]    r_op;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    int            r_mode;

    initial begin
        vecs[0]  = '{OP_DUMP,   5'd0,  32'h0,         0, 3,  1'b0};
        vecs[1]  = '{OP_DUMP,   5'd0,  32'h0,         1, 3,  1'b0};
        vecs[2]  = '{OP_HALT,   5'd0,  32'h0,         0, -1, 1'b1};
        vecs[3]  = '{OP_HALT,   5'd0,  32'h0,         0, -1, 1'b1};
        vecs[4]  = '{OP_WRITE,  5'd5,  32'hDEADBEEF,  0, 0,  1'b1};
        vecs[5]  = '{OP_WRITE,  5'd0,  32'h12345678,  0, 0,  1'b1};
        vecs[6]  = '{OP_DUMP,   5'd0,  32'h0,         0, 1,  1'b1};
        vecs[7]  = '{OP_RESUME, 5'd0,  32'h0,         0, -1, 1'b0};
        vecs[8]  = '{OP_RESUME, 5'd0,  32'h0,         0, -1, 1'b0};
        vecs[9]  = '{OP_WRITE,  5'd31, 32'hA5A5A5A5,  0, 2,  1'b0};
        vecs[10] = '{OP_DUMP,   5'd0,  32'h0,         2, 3,  1'b0};
        vecs[11] = '{OP_HALT,   5'd0,  32'h0,         0, -1, 1'b1};
        vecs[12] = '{OP_RESUME, 5'd0,  32'h0,         0, -1, 1'b0};

        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; dump_ready = 1'b0;
        model_reset();
        tick();
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_dump_valid", 32'(dump_valid), 32'd0);
        check("rst_dump_data", dump_data, 32'd0);
        check("rst_dump_last", 32'(dump_last), 32'd0);
        check("rst_cpu_stop", 32'(cm_cpu_stop), 32'd0);
        check("rst_addr", 32'(rf_addr), 32'd0);
        check("rst_wdat", rf_wdat, 32'd0);
        check("rst_wr", 32'(rf_wr), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        rst = 1'b1;
        tick();
        check("idle_ready", 32'(cmd_ready), 32'd1);

        // Command table
        foreach (vecs[i]) begin
            do_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].mode, vecs[i].exp_lat);
            check("table_halted", 32'(halted), 32'(vecs[i].exp_halted));
        end

        // Reset while halted clears halt and stop
        do_cmd(OP_HALT, '0, '0, 0, -1);
        rst = 1'b0;
        tick();
        check("rst_halt_halted", 32'(halted), 32'd0);
        check("rst_halt_stop", 32'(cm_cpu_stop), 32'd0);
        rst = 1'b1;
        model_reset();
        tick();

        // DUMP held on the command port across a whole dump is taken exactly once more
        cmd_valid = 1'b1; cmd_op = OP_DUMP; cmd_addr = '0; cmd_data = '0; dump_ready = 1'b1;
        acc = 0; words = 0; words_at_2nd = -1; k = 0;
        while (k < 1000) begin
            if (cmd_valid && cmd_ready) begin
                acc++;
                if (acc == 2) words_at_2nd = words;
            end
            if (dump_valid && dump_ready) words++;
            if (acc == 2 && words == 2 * int'(NR) && cmd_ready) break;
            tick();
            k++;
            if (acc >= 2) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        check("held_cmd_accepts", 32'(acc), 32'd2);
        check("held_cmd_words_before_2nd", 32'(words_at_2nd), 32'(NR));
        check("held_cmd_total_words", 32'(words), 32'(2 * NR));
        check("held_cmd_idle", 32'(cmd_ready), 32'd1);

        // Reset on the 10th dump word aborts; the next DUMP starts from address 0
        cmd_valid = 1'b1; cmd_op = OP_DUMP; dump_ready = 1'b1;
        k = 0;
        while (!cmd_ready && k < 100) begin tick(); k++; end
        tick();
        cmd_valid = 1'b0;
        words = 0; k = 0;
        while (k < 500) begin
            if (dump_valid && dump_ready) begin
                words++;
                if (words == 10) break;
            end
            tick();
            k++;
        end
        check("abort_reached_10th", 32'(words), 32'd10);
        rst = 1'b0;
        tick();
        check("abort_dump_valid", 32'(dump_valid), 32'd0);
        check("abort_dump_last", 32'(dump_last), 32'd0);
        check("abort_cpu_stop", 32'(cm_cpu_stop), 32'd0);
        check("abort_addr", 32'(rf_addr), 32'd0);
        rst = 1'b1;
        dump_ready = 1'b0;
        model_reset();
        tick();
        do_cmd(OP_DUMP, '0, '0, 0, 3);

        // Randomized commands against the model
        for (int n = 0; n < 24; n++) begin
            r_op   = 2'($urandom_range(0, 3));
            r_addr = AW'($urandom_range(0, NR - 1));
            r_data = $urandom;
            r_mode = $urandom_range(0, 2);
            do_cmd(r_op, r_addr, r_data, r_mode, exp_k(r_op, ref_halted));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
